a2d_sweep_sched: RTL

//   Sequences the shared SPI master through the off-chip ADC128S.
//   On each nxt trigger, performs one round-robin sweep of ld_cell_lft, ld_cell_rght, steerPot and batt.

---
 rtl/a2d_pkg.sv | 28 ++
 rtl/a2d_sweep_sched.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/a2d_pkg.sv
// Shared types and constants for the ADC128S sweep scheduler: channel codes,
// the per-sweep channel sequence, FSM state encoding and SPI command packing.
package a2d_pkg;

  typedef logic [2:0] chan_t;

  localparam chan_t CH_LFT   = 3'd0;
  localparam chan_t CH_RGHT  = 3'd4;
  localparam chan_t CH_STEER = 3'd5;
  localparam chan_t CH_BATT  = 3'd6;

  localparam int NUM_SLOTS = 5;

  // The trailing CH_LFT is a dummy select that flushes the batt result back.
  localparam chan_t SEQ [NUM_SLOTS] = '{CH_LFT, CH_RGHT, CH_STEER, CH_BATT, CH_LFT};

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    GAP
  } state_t;

  function automatic logic [15:0] mk_cmd(input chan_t c);
    return {2'b00, c, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_sweep_sched.sv
// Round-robin ADC128S sweep sequencer driving the shared SPI master.
// Optional abort-on-stall watchdog enabled with `define A2D_SCHED_TIMEOUT_EN.
module a2d_sweep_sched
  import a2d_pkg::*;
#(
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] resp,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        sweep_vld,
  output logic        busy,
  output logic        timeout_err
);

  state_t      state, state_d;
  logic [2:0]  slot;
  logic        pending;
  logic [15:0] cnt;

  logic load_gap;
  logic load_wait;
  logic latch_en;
  logic last_done;
  logic abort;

  // The ADC only returns 12 significant bits; the upper nibble is always zero.
  logic resp_unused;
  assign resp_unused = ^resp[15:12];

  assign wrt  = (state == LAUNCH);
  assign busy = (state != IDLE);

  always_comb begin
    state_d   = state;
    load_gap  = 1'b0;
    load_wait = 1'b0;
    latch_en  = 1'b0;
    last_done = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (nxt || pending) state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d = WAIT;
`ifdef A2D_SCHED_TIMEOUT_EN
        load_wait = 1'b1;
`endif
      end
      WAIT: begin
        if (done) begin
          latch_en = (slot != 3'd0);
          if (slot == 3'd4) begin
            state_d   = IDLE;
            last_done = 1'b1;
          end else begin
            state_d  = GAP;
            load_gap = 1'b1;
          end
        end
`ifdef A2D_SCHED_TIMEOUT_EN
        else if (cnt == 16'd0) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
`endif
      end
      GAP: begin
        if (cnt == 16'd0) state_d = LAUNCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers: state, slot, request latch and the shared gap/watchdog counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      slot      <= 3'd0;
      pending   <= 1'b0;
      cnt       <= 16'd0;
      cmd       <= 16'h0000;
      sweep_vld <= 1'b0;
    end else begin
      state     <= state_d;
      sweep_vld <= last_done;

      if (state == IDLE || abort) pending <= 1'b0;
      else if (nxt)               pending <= 1'b1;

      if (state == IDLE || abort || last_done) slot <= 3'd0;
      else if (load_gap)                       slot <= slot + 3'd1;

      if (load_gap)         cnt <= 16'(GAP_CYC - 1);
      else if (load_wait)   cnt <= 16'(TIMEOUT_CYC - 1);
      else if (cnt != 16'd0) cnt <= cnt - 16'd1;

      // Slot is already advanced (or zeroed in IDLE) when LAUNCH is entered.
      if (state_d == LAUNCH) cmd <= mk_cmd(SEQ[slot]);
    end
  end

  // Result registers: resp belongs to the channel selected one transaction earlier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'h000;
    end else if (latch_en) begin
      case (slot)
        3'd1:    lft_ld    <= resp[11:0];
        3'd2:    rght_ld   <= resp[11:0];
        3'd3:    steer_pot <= resp[11:0];
        3'd4:    batt      <= resp[11:0];
        default: ;
      endcase
    end
  end

`ifdef A2D_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        timeout_err <= 1'b0;
    else if (abort) timeout_err <= 1'b1;
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
